ws2812_status_mixer: RTL

WS2812_STATUS_MIXER -- requirements
Module: ws2812_status_mixer

---
 rtl/ws2812_pkg.sv | 21 ++
 rtl/led_channel_ramp.sv | 23 ++
 rtl/ws2812_status_mixer.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/ws2812_pkg.sv
// Shared types and constants for the WS2812 status mixer.
// Holds the FSM state enum, GRB channel field positions and colour width.
package ws2812_pkg;

  typedef enum logic [1:0] {
    BOOT_R,
    BOOT_G,
    BOOT_B,
    RUN
  } state_t;

  localparam int COLOR_W = 24;

  localparam int G_HI = 23;
  localparam int G_LO = 16;
  localparam int R_HI = 15;
  localparam int R_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;

endpackage

// File: rtl/led_channel_ramp.sv
// One colour channel: level register stepping by 1 toward its target.
// Ports: clk, reset, i_step (advance enable), i_target, o_level.
module led_channel_ramp (
  input  logic       clk,
  input  logic       reset,
  input  logic       i_step,
  input  logic [7:0] i_target,
  output logic [7:0] o_level
);

  always_ff @(posedge clk) begin
    if (reset) begin
      o_level <= 8'd0;
    end else if (i_step) begin
      if (o_level < i_target) begin
        o_level <= o_level + 8'd1;
      end else if (o_level > i_target) begin
        o_level <= o_level - 8'd1;
      end
    end
  end

endmodule

// File: rtl/ws2812_status_mixer.sv
// Mixes status LEDs into a faded GRB colour for a WS2812 serialiser.
// Ports: clk, reset, caps/shift/motor leds, activity in; color out.
module ws2812_status_mixer
  import ws2812_pkg::*;
#(
  parameter int         CLK_FRE    = 48_000_000,
  parameter int         STEP_HZ    = 1000,
  parameter logic [7:0] MAX_LEVEL  = 8'h40,
  parameter int         BOOT_STEPS = 250,
  parameter int         HOLD_STEPS = 50
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               caps_lock_led,
  input  logic               shift_lock_led,
  input  logic               motor_led,
  input  logic               activity,
  output logic [COLOR_W-1:0] color
);

  localparam int DIV = CLK_FRE / STEP_HZ;
  localparam int TW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW  = (BOOT_STEPS > 1) ? $clog2(BOOT_STEPS) : 1;
  localparam int HW  = $clog2(HOLD_STEPS + 1);

  logic [1:0]    r_caps_s;
  logic [1:0]    r_shift_s;
  logic [1:0]    r_motor_s;
  logic [1:0]    r_act_s;
  logic          r_act_d;
  logic [TW-1:0] r_tick_cnt;
  logic [BW-1:0] r_boot_cnt;
  logic [HW-1:0] r_hold;
  state_t        r_state;

  logic         w_tick;
  logic         w_act_rise;
  logic         w_step;
  logic         w_boost;
  logic [7:0]   w_tgt_r;
  logic [7:0]   w_tgt_g;
  logic [7:0]   w_tgt_b;
  logic [7:0]   w_lvl_r;
  logic [7:0]   w_lvl_g;
  logic [7:0]   w_lvl_b;
  logic [COLOR_W-1:0] w_run_color;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_caps_s  <= '0;
      r_shift_s <= '0;
      r_motor_s <= '0;
      r_act_s   <= '0;
    end else begin
      r_caps_s  <= {r_caps_s[0], caps_lock_led};
      r_shift_s <= {r_shift_s[0], shift_lock_led};
      r_motor_s <= {r_motor_s[0], motor_led};
      r_act_s   <= {r_act_s[0], activity};
    end
  end

  assign w_tick     = (r_tick_cnt == TW'(DIV - 1));
  assign w_act_rise = r_act_s[1] & ~r_act_d;
  assign w_step     = w_tick && (r_state == RUN);
  assign w_boost    = (r_hold != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
    end
  end

  // Targets use registered inputs, so a change landing on a tick
  // only influences the following tick.
  assign w_tgt_r = (r_caps_s[1]  | w_boost) ? MAX_LEVEL : 8'd0;
  assign w_tgt_g = (r_shift_s[1] | w_boost) ? MAX_LEVEL : 8'd0;
  assign w_tgt_b = (r_motor_s[1] | w_boost) ? MAX_LEVEL : 8'd0;

  led_channel_ramp u_ramp_r (
    .clk      (clk),
    .reset    (reset),
    .i_step   (w_step),
    .i_target (w_tgt_r),
    .o_level  (w_lvl_r)
  );

  led_channel_ramp u_ramp_g (
    .clk      (clk),
    .reset    (reset),
    .i_step   (w_step),
    .i_target (w_tgt_g),
    .o_level  (w_lvl_g)
  );

  led_channel_ramp u_ramp_b (
    .clk      (clk),
    .reset    (reset),
    .i_step   (w_step),
    .i_target (w_tgt_b),
    .o_level  (w_lvl_b)
  );

  always_comb begin
    w_run_color             = '0;
    w_run_color[G_HI:G_LO]  = w_lvl_g;
    w_run_color[R_HI:R_LO]  = w_lvl_r;
    w_run_color[B_HI:B_LO]  = w_lvl_b;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= BOOT_R;
      r_boot_cnt <= '0;
      r_hold     <= '0;
      r_act_d    <= 1'b0;
      color      <= '0;
    end else begin
      r_act_d <= r_act_s[1];
      color   <= '0;
      unique case (r_state)
        BOOT_R: color[R_HI:R_LO] <= MAX_LEVEL;
        BOOT_G: color[G_HI:G_LO] <= MAX_LEVEL;
        BOOT_B: color[B_HI:B_LO] <= MAX_LEVEL;
        RUN:    color            <= w_run_color;
      endcase
      if (r_state != RUN) begin
        if (w_tick) begin
          if (r_boot_cnt == BW'(BOOT_STEPS - 1)) begin
            r_boot_cnt <= '0;
            unique case (r_state)
              BOOT_R:  r_state <= BOOT_G;
              BOOT_G:  r_state <= BOOT_B;
              default: r_state <= RUN;
            endcase
          end else begin
            r_boot_cnt <= r_boot_cnt + 1'b1;
          end
        end
      end else begin
        // A fresh activity edge wins over the tick decrement.
        if (w_act_rise) begin
          r_hold <= HW'(HOLD_STEPS);
        end else if (w_tick && w_boost) begin
          r_hold <= r_hold - 1'b1;
        end
      end
    end
  end

endmodule
